nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-nibble add/subtract sequencer that drives the team's combinational 4-bit ripple adder.
- Accepts two wide operands over a valid/ready handshake.
- Feeds them to the external 4-bit adder one nibble per cycle, least significant first, chaining the carry through a register.
- Returns the assembled result, carry-out and signed overflow over a second valid/ready handshake.
- Sits between the operand source and the result consumer; the 4-bit adder is instantiated beside it and wired to the add_* ports.

## Interface
- NIBBLES, 4, operand width in nibbles (W = 4*NIBBLES); legal range 2..16
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept an operand (high only in IDLE)
- op_a  input  W  operand A
- op_b  input  W  operand B
- op_cin  input  1  carry-in for add mode; ignored when op_sub=1
- op_sub  input  1  1 = A − B, 0 = A + B + op_cin
- add_a  output  4  nibble of A to adder
- add_b  output  4  nibble of B (inverted when subtracting) to adder
- add_cin  output  1  chained carry to adder
- add_sum  input  4  adder Sum
- add_cout  input  1  adder Cout
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  W  sum/difference
- cout  output  1  final carry; in subtract mode 1 = no borrow
- overflow  output  1  two's-complement overflow of the W-bit operation

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on in_valid && in_ready.
  - RUN→DONE after nibble NIBBLES-1 is captured.
  - DONE→IDLE on out_valid && out_ready.
- On accept, latch the following and set idx=0:
  - a_reg = op_a
  - b_reg = op_sub ? ~op_b : op_b
  - carry_reg = op_sub ? 1 : op_cin
- add_* outputs in RUN (combinational): add_a = a_reg[4*idx+:4], add_b = b_reg[4*idx+:4], add_cin = carry_reg.
- add_* outputs in IDLE/DONE: all zero.
- Each RUN edge:
  - result[4*idx+:4] <= add_sum
  - carry_reg <= add_cout
  - idx <= idx+1
- Overflow, computed on the last RUN edge from MSB bits: overflow <= (a_reg[W-1] == b_reg[W-1]) && (add_sum[3] != a_reg[W-1]).
- cout <= add_cout on the last RUN edge.
- result, cout and overflow hold stable from DONE entry until the output handshake completes. They keep their values in IDLE until the next accept.
- result is cleared to 0 on accept.
- in_ready is low in RUN and DONE. A new request is never accepted on the same edge as the output handshake.

## Timing
- Reset values:
  - state IDLE, in_ready 1, out_valid 0
  - result 0, cout 0, overflow 0
  - add_a/add_b/add_cin 0
  - internal registers 0
- Reset asserted at any time, including mid-RUN or in DONE:
  - Returns the block immediately to IDLE with the reset values above.
  - A partially built result is discarded.
  - Inputs are ignored while rst_n is low.
- Latency:
  - Accept at edge T.
  - RUN occupies cycles T..T+NIBBLES-1.
  - out_valid rises after edge T+NIBBLES.
- Earliest next accept is the edge after the output handshake.
- Back-to-back throughput: one operation per NIBBLES+2 cycles.
- The external adder path is combinational. add_sum/add_cout are sampled in the same cycle that add_a/add_b/add_cin are driven.
- out_valid, once high, stays high until out_ready is sampled high.
- Operand inputs may change after the accept edge without effect.

## Test plan
All scenarios use NIBBLES=4.
- Add: A=0x1234, B=0x0FCD, cin=0 → result 0x2201, cout 0, overflow 0; out_valid rises exactly 4 edges after accept.
- Carry chain: A=0xFFFF, B=0x0001, cin=0 → result 0x0000, cout 1, overflow 0; add_cin=1 on nibbles 1..3.
- Signed overflow and subtract, back-to-back:
  - A=0x7FFF + B=0x0001 → 0x8000, overflow 1.
  - A=0x0005 − B=0x0007 → 0xFFFE, cout 0, overflow 0.
  - A=0x8000 − B=0x0001 → 0x7FFF, cout 1, overflow 1.
- Backpressure: out_ready held low 5 cycles in DONE → result/cout/overflow stable, in_ready stays 0, in_valid pulses ignored; release → one handshake, IDLE next cycle.
- Reset mid-RUN: assert rst_n=0 after 2 nibbles of 0xABCD+0x1111 → out_valid 0, result 0, in_ready 1 immediately. A subsequent 0x0001+0x0002 yields 0x0003.
- Carry-in: A=0x00FF, B=0x0000, cin=1, sub=0 → 0x0100; same operands with sub=1 → 0x00FF, cout 1 (op_cin ignored).

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Multi-nibble add/subtract sequencer driving an external 4-bit ripple adder.
// Operands are fed one nibble per cycle, LSB first, with the carry chained through a register.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 op_cin,
    input  logic                 op_sub,
    output logic [3:0]           add_a,
    output logic [3:0]           add_b,
    output logic                 add_cin,
    input  logic [3:0]           add_sum,
    input  logic                 add_cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 overflow
);

    localparam int IDX_W = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [NIBBLES-1:0][3:0]  r_a;
    logic [NIBBLES-1:0][3:0]  r_b;
    logic [NIBBLES-1:0][3:0]  r_result;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_carry;
    logic                     r_cout;
    logic                     r_ovf;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_out_hs;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_idx == IDX_W'(NIBBLES - 1));
    assign w_out_hs = (r_state == S_DONE) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  if (w_out_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Adder operands are driven only while a nibble is being processed.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = 4'd0;
        add_b     = 4'd0;
        add_cin   = 1'b0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_RUN: begin
                add_a   = r_a[r_idx];
                add_b   = r_b[r_idx];
                add_cin = r_carry;
            end
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= op_a;
                        r_b      <= op_sub ? ~op_b : op_b;
                        r_carry  <= op_sub ? 1'b1 : op_cin;
                        r_result <= '0;
                        r_idx    <= '0;
                    end
                end
                S_RUN: begin
                    r_result[r_idx] <= add_sum;
                    r_carry         <= add_cout;
                    r_idx           <= r_idx + 1'b1;
                    // Sign of the top nibble sum decides two's-complement overflow.
                    if (w_last) begin
                        r_cout <= add_cout;
                        r_ovf  <= (r_a[NIBBLES-1][3] == r_b[NIBBLES-1][3]) &&
                                  (add_sum[3] != r_a[NIBBLES-1][3]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (NIBBLES=4) with a behavioural 4-bit adder beside it.
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic         op_sub;
    logic [3:0]   add_a;
    logic [3:0]   add_b;
    logic         add_cin;
    logic [3:0]   add_sum;
    logic         add_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] exp_res;
        logic        exp_cout;
        logic        exp_ovf;
        logic [3:0]  exp_cins;
    } vec_t;

    vec_t vecs[8];

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_cin   (op_cin),
        .op_sub   (op_sub),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_op(input vec_t v, input string name);
        logic [3:0] cins;
        cins = 4'd0;
        @(negedge clk);
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op_a     = v.a;
        op_b     = v.b;
        op_cin   = v.cin;
        op_sub   = v.sub;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = 16'($urandom);
        op_b     = 16'($urandom);
        op_cin   = 1'($urandom);
        op_sub   = 1'($urandom);
        chk({name, " result_clear"}, 32'(result), 32'd0);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            cins[k] = add_cin;
            chk({name, " out_valid_early"}, 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
        end
        chk({name, " out_valid"}, 32'(out_valid), 32'd1);
        chk({name, " result"}, 32'(result), 32'(v.exp_res));
        chk({name, " cout"}, 32'(cout), 32'(v.exp_cout));
        chk({name, " overflow"}, 32'(overflow), 32'(v.exp_ovf));
        chk({name, " add_cin_seq"}, 32'(cins), 32'(v.exp_cins));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({name, " out_valid_drop"}, 32'(out_valid), 32'd0);
        chk({name, " in_ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //                a        b        cin   sub   res      cout  ovf   cins
        vecs[0] = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0, 4'b1110};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 4'b0001};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 4'b0001};
        vecs[5] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 4'b0111};
        vecs[6] = '{16'h00FF, 16'h0000, 1'b1, 1'b1, 16'h00FF, 1'b1, 1'b0, 4'b1111};
        vecs[7] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 4'b0000};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_cin    = 1'b0;
        op_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset cout", 32'(cout), 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset add_bus", 32'({add_a, add_b, add_cin}), 32'd0);

        // Back-to-back table of operations.
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: 0x4321 + 0x1111 held in DONE for five cycles.
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = 16'h4321;
        op_b     = 16'h1111;
        op_cin   = 1'b0;
        op_sub   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (N) @(posedge clk);
        #1;
        chk("bp out_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            op_a     = 16'h0101;
            @(negedge clk);
            chk("bp result", 32'(result), 32'h5432);
            chk("bp cout", 32'(cout), 32'd0);
            chk("bp overflow", 32'(overflow), 32'd0);
            chk("bp in_ready", 32'(in_ready), 32'd0);
            chk("bp out_valid_hold", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp release out_valid", 32'(out_valid), 32'd0);
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        chk("bp idle out_valid", 32'(out_valid), 32'd0);
        chk("bp idle result_kept", 32'(result), 32'h5432);

        // Reset in the middle of 0xABCD + 0x1111 after two nibbles.
        in_valid = 1'b1;
        op_a     = 16'hABCD;
        op_b     = 16'h1111;
        op_cin   = 1'b0;
        op_sub   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst partial result", 32'(result), 32'h00DE);
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst result", 32'(result), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst add_bus", 32'({add_a, add_b, add_cin}), 32'd0);
        in_valid = 1'b1;
        op_a     = 16'h5555;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst held in_ready", 32'(in_ready), 32'd1);
        chk("rst held add_bus", 32'({add_a, add_b, add_cin}), 32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        do_op(vecs[7], "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
